// File: rtl/imm_enc_pkg.sv
// -----------------------------------------------------------------------------
// imm_enc_pkg
// Shared definitions for the immediate encoder:
//   - immediate class codes (IMM_M, IMM_BR, IMM_LDI, IMM_LDUI). These are the
//     same codes the immediate generator decodes, so both sides agree on what
//     a given out_imm_sel value means. Code 0 is reserved for "no class",
//     which the encoder emits on error beats.
//   - encoder FSM state enum
//   - beat record held in the output register
// -----------------------------------------------------------------------------
package imm_enc_pkg;

    localparam int IMM_SRC_W = 25;   // instruction immediate field width
    localparam int IMM_SEL_W = 3;    // immediate class code width
    localparam int VALUE_W   = 64;   // request value width
    localparam int HI_W      = 15;   // LDUI payload width (value[31:17])

    // Immediate class codes, shared with the immediate generator.
    localparam logic [IMM_SEL_W-1:0] IMM_NONE = 3'd0;
    localparam logic [IMM_SEL_W-1:0] IMM_M    = 3'd1;
    localparam logic [IMM_SEL_W-1:0] IMM_BR   = 3'd2;
    localparam logic [IMM_SEL_W-1:0] IMM_LDI  = 3'd3;
    localparam logic [IMM_SEL_W-1:0] IMM_LDUI = 3'd4;

    // IDLE serves all 1-beat requests; SEND1/SEND2 cover the two beats of a
    // split LDI/LDUI constant.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND1 = 2'd1,
        SEND2 = 2'd2
    } state_e;

    // One encoded beat as presented on the output port.
    typedef struct packed {
        logic [IMM_SRC_W-1:0] imm_src;
        logic [IMM_SEL_W-1:0] imm_sel;
        logic                 last;
        logic                 err;
    } beat_t;

endpackage

// File: rtl/imm_enc_pack.sv
// -----------------------------------------------------------------------------
// imm_enc_pack
// Purely combinational range checking and field packing for one request.
// It produces the first (or only) beat and, for a split LDI constant, the
// 15-bit payload of the following LDUI beat.
//
// Ports:
//   kind_i      in   3   requested immediate class
//   value_i     in  64   immediate or constant to encode
//   imm_src_o   out 25   packed immediate field of the first beat
//   imm_sel_o   out  3   class of the first beat (IMM_NONE on error)
//   err_o       out  1   value not encodable for this class / unknown class
//   two_beat_o  out  1   request needs a trailing LDUI beat
//   hi_src_o    out 15   LDUI payload (value[31:17]), meaningful with two_beat_o
// -----------------------------------------------------------------------------
module imm_enc_pack
    import imm_enc_pkg::*;
(
    input  logic [IMM_SEL_W-1:0] kind_i,
    input  logic [VALUE_W-1:0]   value_i,
    output logic [IMM_SRC_W-1:0] imm_src_o,
    output logic [IMM_SEL_W-1:0] imm_sel_o,
    output logic                 err_o,
    output logic                 two_beat_o,
    output logic [HI_W-1:0]      hi_src_o
);

    logic m_fits;      // value is the sign-extension of value[9:0]
    logic br_fits;     // only bit 16 and bits [11:0] may be set
    logic ldi_short;   // value is the sign-extension of value[19:0]
    logic ldi_long;    // value fits in an unsigned 32-bit constant

    // A value is the sign-extension of its low N bits exactly when bits
    // [63:N-1] are all equal, i.e. all ones or all zeros.
    assign m_fits    = (&value_i[63:9])  || (~|value_i[63:9]);
    assign ldi_short = (&value_i[63:19]) || (~|value_i[63:19]);
    assign ldi_long  = ~|value_i[63:32];
    assign br_fits   = (~|value_i[63:17]) && (~|value_i[15:12]);

    // The upper half of a split constant overlaps the low beat in bits
    // [19:17]; the generator rebuilds value as {hi, lo[16:0]}.
    assign hi_src_o = value_i[31:17];

    // NOTE: every output of a combinational block gets a default before the
    // case statement, so no path leaves a signal unassigned and no latch is
    // inferred.
    always_comb begin
        imm_src_o  = '0;
        imm_sel_o  = IMM_NONE;
        err_o      = 1'b0;
        two_beat_o = 1'b0;
        case (kind_i)
            IMM_M: begin
                if (m_fits) begin
                    imm_src_o[9:0] = value_i[9:0];
                    imm_sel_o      = IMM_M;
                end else begin
                    err_o = 1'b1;
                end
            end
            IMM_BR: begin
                if (br_fits) begin
                    imm_src_o[16]   = value_i[16];
                    imm_src_o[15:4] = value_i[11:0];
                    imm_sel_o       = IMM_BR;
                end else begin
                    err_o = 1'b1;
                end
            end
            IMM_LDI: begin
                if (ldi_short || ldi_long) begin
                    imm_src_o[19:0] = value_i[19:0];
                    imm_sel_o       = IMM_LDI;
                    two_beat_o      = !ldi_short;
                end else begin
                    err_o = 1'b1;
                end
            end
            default: begin
                // IMM_LDUI is an output-only class; it and unused codes are
                // rejected like any other unencodable request.
                err_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_enc.sv
// -----------------------------------------------------------------------------
// imm_enc
// Immediate encoder: accepts a {kind, 64-bit value} request and emits one or
// two encoded immediate beats on a valid/ready output. All outputs are
// registered; the first beat appears one cycle after acceptance. A 1-beat
// request can be accepted in the same cycle the previous last beat is taken,
// giving one request per cycle. Split LDI constants walk IDLE -> SEND1 ->
// SEND2 -> IDLE, and no new request is accepted while in SEND1/SEND2.
//
// Configuration:
//   IMM_ENC_STATS_EN  when defined, enc_cnt counts accepted requests and
//                     err_cnt counts taken error beats, both saturating.
//                     When undefined, both outputs are tied to zero and no
//                     counter flops exist.
//
// Ports:
//   clk          in   1      clock, rising edge
//   rst          in   1      asynchronous, active-high reset
//   in_valid     in   1      request present
//   in_ready     out  1      request accepted this cycle when in_valid
//   in_kind      in   3      IMM_M / IMM_BR / IMM_LDI
//   in_value     in  64      value to encode
//   out_valid    out  1      beat presented
//   out_ready    in   1      consumer takes the beat
//   out_imm_src  out 25      instruction immediate field
//   out_imm_sel  out  3      immediate class of the beat
//   out_last     out  1      final beat of the request
//   out_err      out  1      request unencodable (payload zero)
//   enc_cnt      out CNT_W   accepted-request counter
//   err_cnt      out CNT_W   error-beat counter
// -----------------------------------------------------------------------------
module imm_enc
    import imm_enc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IMM_SEL_W-1:0] in_kind,
    input  logic [VALUE_W-1:0]   in_value,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [IMM_SRC_W-1:0] out_imm_src,
    output logic [IMM_SEL_W-1:0] out_imm_sel,
    output logic                 out_last,
    output logic                 out_err,
    output logic [CNT_W-1:0]     enc_cnt,
    output logic [CNT_W-1:0]     err_cnt
);

    state_e            state_q;
    logic              out_valid_q;
    beat_t             beat_q;
    logic [HI_W-1:0]   hi_q;       // pending LDUI payload while in SEND1

    logic [IMM_SRC_W-1:0] pk_imm_src;
    logic [IMM_SEL_W-1:0] pk_imm_sel;
    logic                 pk_err;
    logic                 pk_two_beat;
    logic [HI_W-1:0]      pk_hi_src;

    logic accept;   // request transfer this cycle
    logic take;     // output beat transfer this cycle

    imm_enc_pack u_pack (
        .kind_i     (in_kind),
        .value_i    (in_value),
        .imm_src_o  (pk_imm_src),
        .imm_sel_o  (pk_imm_sel),
        .err_o      (pk_err),
        .two_beat_o (pk_two_beat),
        .hi_src_o   (pk_hi_src)
    );

    // The output register is free when it is empty or its beat leaves now.
    assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign take     = out_valid_q && out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement
    // order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            beat_q      <= '0;
            hi_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        out_valid_q    <= 1'b1;
                        beat_q.imm_src <= pk_imm_src;
                        beat_q.imm_sel <= pk_imm_sel;
                        beat_q.err     <= pk_err;
                        beat_q.last    <= !pk_two_beat;
                        hi_q           <= pk_hi_src;
                        state_q        <= pk_two_beat ? SEND1 : IDLE;
                    end else if (take) begin
                        // Payload is left as-is; only the valid flag drops.
                        out_valid_q <= 1'b0;
                    end
                end
                SEND1: begin
                    // LDI beat is on the port; swap in LDUI once it is taken.
                    if (out_ready) begin
                        beat_q.imm_src <= {{(IMM_SRC_W-HI_W){1'b0}}, hi_q};
                        beat_q.imm_sel <= IMM_LDUI;
                        beat_q.err     <= 1'b0;
                        beat_q.last    <= 1'b1;
                        state_q        <= SEND2;
                    end
                end
                SEND2: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign out_valid   = out_valid_q;
    assign out_imm_src = beat_q.imm_src;
    assign out_imm_sel = beat_q.imm_sel;
    assign out_last    = beat_q.last;
    assign out_err     = beat_q.err;

`ifdef IMM_ENC_STATS_EN
    logic [CNT_W-1:0] enc_cnt_q, enc_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Saturating counters: hold at all-ones instead of wrapping.
    always_comb begin
        enc_cnt_d = enc_cnt_q;
        err_cnt_d = err_cnt_q;
        if (accept && !(&enc_cnt_q)) begin
            enc_cnt_d = enc_cnt_q + CNT_W'(1);
        end
        if (take && beat_q.err && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enc_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            enc_cnt_q <= enc_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign enc_cnt = enc_cnt_q;
    assign err_cnt = err_cnt_q;
`else
    assign enc_cnt = '0;
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_imm_enc.sv
// -----------------------------------------------------------------------------
// tb_imm_enc
// Self-checking bench for imm_enc: a table of directed vectors with
// hand-computed expected beats, randomized requests checked against a
// behavioural model working on plain integer arithmetic, and hand-written
// sequences for output stalls, back-to-back throughput and reset in SEND1.
// Statistics expectations follow IMM_ENC_STATS_EN.
// -----------------------------------------------------------------------------
module tb_imm_enc;
    import imm_enc_pkg::*;

    localparam int CNT_W = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           in_kind;
    logic [63:0]          in_value;
    logic                 out_valid;
    logic                 out_ready;
    logic [24:0]          out_imm_src;
    logic [2:0]           out_imm_sel;
    logic                 out_last;
    logic                 out_err;
    logic [CNT_W-1:0]     enc_cnt;
    logic [CNT_W-1:0]     err_cnt;

    imm_enc #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_kind     (in_kind),
        .in_value    (in_value),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_imm_src (out_imm_src),
        .out_imm_sel (out_imm_sel),
        .out_last    (out_last),
        .out_err     (out_err),
        .enc_cnt     (enc_cnt),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [24:0] src;
        logic [2:0]  sel;
        logic        last;
        logic        err;
    } exp_beat_t;

    typedef struct {
        int        n;
        exp_beat_t b0;
        exp_beat_t b1;
    } exp_req_t;

    typedef struct {
        string       name;
        logic [2:0]  kind;
        logic [63:0] value;
        int          n;
        logic [24:0] src0;
        logic [2:0]  sel0;
        logic        err0;
        logic [24:0] src1;
    } vec_t;

    vec_t vecs[$];

    int n_checks = 0;
    int n_pass   = 0;
    int exp_enc  = 0;
    int exp_err  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_beat(input string name, input exp_beat_t e, input logic exp_rdy);
        check({name, " out_valid"}, 64'(out_valid), 64'(1'b1));
        check({name, " imm_src"},   64'(out_imm_src), 64'(e.src));
        check({name, " imm_sel"},   64'(out_imm_sel), 64'(e.sel));
        check({name, " last"},      64'(out_last), 64'(e.last));
        check({name, " err"},       64'(out_err), 64'(e.err));
        check({name, " in_ready"},  64'(in_ready), 64'(exp_rdy));
    endtask

    task automatic check_counters(input string name);
`ifdef IMM_ENC_STATS_EN
        check({name, " enc_cnt"}, 64'(enc_cnt), 64'(exp_enc));
        check({name, " err_cnt"}, 64'(err_cnt), 64'(exp_err));
`else
        check({name, " enc_cnt"}, 64'(enc_cnt), 64'd0);
        check({name, " err_cnt"}, 64'(err_cnt), 64'd0);
`endif
    endtask

    // Reference model: the encoding rules stated as integer ranges and
    // arithmetic on the value.
    function automatic exp_req_t model(input logic [2:0] kind, input logic [63:0] value);
        exp_req_t r;
        longint   sv;
        sv = longint'(value);
        r.n  = 1;
        r.b0 = '{src: 25'd0, sel: 3'd0, last: 1'b1, err: 1'b1};
        r.b1 = '{src: 25'd0, sel: 3'd0, last: 1'b0, err: 1'b0};
        if (kind == IMM_M && sv >= -512 && sv <= 511) begin
            r.b0 = '{src: 25'(value % 1024), sel: IMM_M, last: 1'b1, err: 1'b0};
        end else if (kind == IMM_BR && value < 64'h2_0000 && (value / 4096) % 16 == 0) begin
            r.b0 = '{src: 25'((value / 65536) * 65536 + (value % 4096) * 16),
                     sel: IMM_BR, last: 1'b1, err: 1'b0};
        end else if (kind == IMM_LDI && sv >= -524288 && sv <= 524287) begin
            r.b0 = '{src: 25'(value % 64'h10_0000), sel: IMM_LDI, last: 1'b1, err: 1'b0};
        end else if (kind == IMM_LDI && value < 64'h1_0000_0000) begin
            r.n  = 2;
            r.b0 = '{src: 25'(value % 64'h10_0000), sel: IMM_LDI, last: 1'b0, err: 1'b0};
            r.b1 = '{src: 25'(value / 64'h2_0000), sel: IMM_LDUI, last: 1'b1, err: 1'b0};
        end
        return r;
    endfunction

    task automatic add_vec(input string name, input logic [2:0] kind, input logic [63:0] value,
                           input int n, input logic [24:0] src0, input logic [2:0] sel0,
                           input logic err0, input logic [24:0] src1);
        vec_t v;
        v.name = name; v.kind = kind; v.value = value; v.n = n;
        v.src0 = src0; v.sel0 = sel0; v.err0 = err0; v.src1 = src1;
        vecs.push_back(v);
    endtask

    // Issue one request with out_ready high at acceptance, then walk its
    // beats. first_stall >= 0 forces that many stall cycles on the first
    // beat; a negative value picks 0..2 random stall cycles per beat.
    task automatic do_req(input string name, input logic [2:0] kind, input logic [63:0] value,
                          input exp_req_t e, input int first_stall);
        logic [24:0] got0;
        logic [24:0] got1;
        logic [63:0] rebuilt;
        exp_beat_t   eb;
        int          stalls;
        got0 = '0;
        got1 = '0;
        @(posedge clk); #1;
        in_valid  = 1'b1;
        in_kind   = kind;
        in_value  = value;
        out_ready = 1'b1;
        @(negedge clk);
        check({name, " accept in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_enc++;
        for (int b = 0; b < e.n; b++) begin
            eb = (b == 0) ? e.b0 : e.b1;
            if (b == 0 && first_stall >= 0) stalls = first_stall;
            else if (first_stall < 0)       stalls = $urandom_range(0, 2);
            else                            stalls = 0;
            for (int s = 0; s <= stalls; s++) begin
                out_ready = (s == stalls);
                @(negedge clk);
                check_beat($sformatf("%s beat%0d", name, b), eb, (e.n == 1) && out_ready);
                if (b == 0) got0 = out_imm_src;
                else        got1 = out_imm_src;
                @(posedge clk); #1;
            end
            if (eb.err) exp_err++;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check({name, " drained out_valid"}, 64'(out_valid), 64'd0);
        check({name, " drained in_ready"},  64'(in_ready), 64'd1);
        if (e.n == 2) begin
            rebuilt = (64'(got1[14:0]) << 17) | 64'(got0[16:0]);
            check({name, " rebuilt"}, rebuilt, value);
        end
    endtask

    task automatic do_reset(input string name);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        check({name, " out_valid"}, 64'(out_valid), 64'd0);
        check({name, " imm_src"},   64'(out_imm_src), 64'd0);
        check({name, " imm_sel"},   64'(out_imm_sel), 64'd0);
        check({name, " last"},      64'(out_last), 64'd0);
        check({name, " err"},       64'(out_err), 64'd0);
        check({name, " in_ready"},  64'(in_ready), 64'd1);
        check({name, " enc_cnt"},   64'(enc_cnt), 64'd0);
        check({name, " err_cnt"},   64'(err_cnt), 64'd0);
        @(posedge clk); #1;
        rst     = 1'b0;
        exp_enc = 0;
        exp_err = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_req_t    e;
        logic [63:0] v;
        logic [63:0] r;
        logic [63:0] b2b_vals[20];
        logic [2:0]  k;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_kind   = '0;
        in_value  = '0;
        out_ready = 1'b1;
        #1;
        do_reset("reset");

        // Directed table: {name, kind, value, beats, src0, sel0, err0, src1}.
        add_vec("m_neg3",    IMM_M,   64'hFFFF_FFFF_FFFF_FFFD, 1, 25'h3FD,   IMM_M,   1'b0, 25'h0);
        add_vec("m_max",     IMM_M,   64'h1FF,                 1, 25'h1FF,   IMM_M,   1'b0, 25'h0);
        add_vec("m_min",     IMM_M,   64'hFFFF_FFFF_FFFF_FE00, 1, 25'h200,   IMM_M,   1'b0, 25'h0);
        add_vec("m_over",    IMM_M,   64'h200,                 1, 25'h0,     3'd0,    1'b1, 25'h0);
        add_vec("m_hi",      IMM_M,   64'h8000_0000_0000_0000, 1, 25'h0,     3'd0,    1'b1, 25'h0);
        add_vec("br_a",      IMM_BR,  64'h1_0ABC,              1, 25'h1ABC0, IMM_BR,  1'b0, 25'h0);
        add_vec("br_gap",    IMM_BR,  64'h1000,                1, 25'h0,     3'd0,    1'b1, 25'h0);
        add_vec("br_low",    IMM_BR,  64'hFFF,                 1, 25'hFFF0,  IMM_BR,  1'b0, 25'h0);
        add_vec("br_top",    IMM_BR,  64'h1_0FFF,              1, 25'h1FFF0, IMM_BR,  1'b0, 25'h0);
        add_vec("br_over",   IMM_BR,  64'h2_0000,              1, 25'h0,     3'd0,    1'b1, 25'h0);
        add_vec("ldi_split", IMM_LDI, 64'h1234_5678,           2, 25'h45678, IMM_LDI, 1'b0, 25'h091A);
        add_vec("ldi_max",   IMM_LDI, 64'h7_FFFF,              1, 25'h7FFFF, IMM_LDI, 1'b0, 25'h0);
        add_vec("ldi_min",   IMM_LDI, 64'hFFFF_FFFF_FFF8_0000, 1, 25'h80000, IMM_LDI, 1'b0, 25'h0);
        add_vec("ldi_neg1",  IMM_LDI, 64'hFFFF_FFFF_FFFF_FFFF, 1, 25'hFFFFF, IMM_LDI, 1'b0, 25'h0);
        add_vec("ldi_b19",   IMM_LDI, 64'h8_0000,              2, 25'h80000, IMM_LDI, 1'b0, 25'h4);
        add_vec("ldi_u32",   IMM_LDI, 64'hFFFF_FFFF,           2, 25'hFFFFF, IMM_LDI, 1'b0, 25'h7FFF);
        add_vec("ldi_wide",  IMM_LDI, 64'h1_0000_0000,         1, 25'h0,     3'd0,    1'b1, 25'h0);
        add_vec("kind0",     3'd0,    64'h0,                   1, 25'h0,     3'd0,    1'b1, 25'h0);
        add_vec("kind_ldui", IMM_LDUI,64'h5,                   1, 25'h0,     3'd0,    1'b1, 25'h0);
        add_vec("kind7",     3'd7,    64'h1,                   1, 25'h0,     3'd0,    1'b1, 25'h0);

        foreach (vecs[i]) begin
            e.n  = vecs[i].n;
            e.b0 = '{src: vecs[i].src0, sel: vecs[i].sel0, last: (vecs[i].n == 1), err: vecs[i].err0};
            e.b1 = '{src: vecs[i].src1, sel: IMM_LDUI, last: 1'b1, err: 1'b0};
            do_req(vecs[i].name, vecs[i].kind, vecs[i].value, e, 0);
        end
        check_counters("after table");

        // Output stalled for 5 cycles while the LDI beat sits in SEND1.
        do_req("stall_send1", IMM_LDI, 64'h1234_5678, model(IMM_LDI, 64'h1234_5678), 5);

        // Randomized requests with random output stalls.
        for (int i = 0; i < 250; i++) begin
            r = {$urandom, $urandom};
            case ($urandom_range(0, 4))
                0:       v = {{52{r[11]}}, r[11:0]};
                1:       v = {{43{r[20]}}, r[20:0]};
                2:       v = {32'd0, r[31:0]};
                3:       v = {47'd0, r[16], ($urandom_range(0, 1) == 0) ? 4'd0 : r[15:12], r[11:0]};
                default: v = r;
            endcase
            k = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 3));
            do_req($sformatf("rand%0d", i), k, v, model(k, v), -1);
        end
        check_counters("after random");

        // Reset in SEND1: the pending LDUI beat must never appear.
        @(posedge clk); #1;
        in_valid  = 1'b1;
        in_kind   = IMM_LDI;
        in_value  = 64'h1234_5678;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_send1 pre last", 64'(out_last), 64'd0);
        check("rst_send1 pre in_ready", 64'(in_ready), 64'd0);
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("rst_send1 out_valid", 64'(out_valid), 64'd0);
        check("rst_send1 in_ready", 64'(in_ready), 64'd1);
        check("rst_send1 imm_src", 64'(out_imm_src), 64'd0);
        exp_enc   = 0;
        exp_err   = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("rst_send1 no beat c%0d", c), 64'(out_valid), 64'd0);
        end
        do_req("after_rst", IMM_BR, 64'h1_0ABC, model(IMM_BR, 64'h1_0ABC), 0);

        // 20 back-to-back 1-beat requests, one beat per cycle.
        do_reset("reset2");
        out_ready = 1'b1;
        for (int i = 0; i <= 20; i++) begin
            if (i < 20) begin
                r           = {32'd0, $urandom};
                b2b_vals[i] = {{54{r[9]}}, r[9:0]};
                in_valid    = 1'b1;
                in_kind     = IMM_M;
                in_value    = b2b_vals[i];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (i == 0) check("b2b first in_ready", 64'(in_ready), 64'd1);
            else        check_beat($sformatf("b2b%0d", i - 1), model(IMM_M, b2b_vals[i - 1]).b0, 1'b1);
            @(posedge clk); #1;
        end
        exp_enc += 20;
        @(negedge clk);
        check("b2b drained out_valid", 64'(out_valid), 64'd0);
`ifdef IMM_ENC_STATS_EN
        check("b2b enc_cnt", 64'(enc_cnt), 64'd20);
`else
        check("b2b enc_cnt", 64'(enc_cnt), 64'd0);
`endif
        check_counters("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
